// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake between a producer and the JK command sequencer.
// The producer offers a 2-bit flop command; the sequencer answers with ready.
`timescale 1ns/1ps
interface jk_cmd_sequencer_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK flop commands in a FIFO, drives j/k for one clock per command,
// then checks the flop's q against the expected result and counts mismatches.
`timescale 1ns/1ps
module jk_cmd_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    jk_cmd_sequencer_if.slave cmd,
    output logic              j,
    output logic              k,
    input  logic              q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [1:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        op;
    logic [1:0]        head;
    logic              q_before;
    logic              expected;
    logic              push;
    logic              pop;

    // Ready depends only on occupancy, so a pop never frees a slot on the same edge.
    assign cmd.cmd_ready = (fifo_cnt != FULL_CNT);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state == IDLE) && (fifo_cnt != '0);
    assign busy          = (state != IDLE);
    assign head          = mem[rd_ptr];

    always_comb begin
        expected = q_before;
        case (op)
            2'b00:   expected = q_before;
            2'b01:   expected = 1'b0;
            2'b10:   expected = 1'b1;
            default: expected = ~q_before;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd.cmd_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            op       <= '0;
            q_before <= 1'b0;
            j        <= 1'b0;
            k        <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (ADDR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (ADDR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        op       <= head;
                        q_before <= q;
                        j        <= head[1];
                        k        <= head[0];
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= CHECK;
                end
                CHECK: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (q != expected) begin
                        err <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
